// File: rtl/rpn_eval_pkg.sv
// rpn_eval shared definitions: op-codes and controller states.
package rpn_eval_pkg;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_DUP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        POP_A,
        POP_B,
        CAP_B,
        PUSH1,
        PUSH2,
        RESULT,
        HALT
    } state_t;

endpackage

// File: rtl/rpn_eval_alu.sv
// rpn_eval arithmetic: y = b+a or b-a; RPN_EVAL_SAT_EN selects clamping.
module rpn_eval_alu #(
    parameter int WIDTH = 11
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] y
);

`ifdef RPN_EVAL_SAT_EN
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, b} + {1'b0, a};
    assign diff = {1'b0, b} - {1'b0, a};

    // Carry clamps to all-ones, borrow clamps to zero
    always_comb begin
        if (sub)
            y = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
        else
            y = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
`else
    always_comb begin
        y = sub ? (b - a) : (b + a);
    end
`endif

endmodule

// File: rtl/rpn_eval.sv
// RPN evaluator controlling an external stack.
// Optional saturating arithmetic via macro RPN_EVAL_SAT_EN.
module rpn_eval
    import rpn_eval_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_d,
    input  logic [WIDTH-1:0] stk_q,
    input  logic             stk_ovf,
    input  logic             stk_unf,
    output logic [DEPTH:0]   depth,
    output logic             err,
    output logic             halt
);

    localparam logic [DEPTH:0] CAP = {1'b0, {DEPTH{1'b1}}};

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] alu_y;
    logic             legal;
    logic             is_arith;

    assign is_arith = (op == OP_ADD) || (op == OP_SUB);

    rpn_eval_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (opnd_a),
        .b   (opnd_b),
        .sub (op == OP_SUB),
        .y   (alu_y)
    );

    always_comb begin
        legal = 1'b1;
        unique case (cmd_op)
            OP_PUSH:        legal = (depth != CAP);
            OP_POP:         legal = (depth != '0);
            OP_ADD, OP_SUB: legal = (depth >= 2);
            OP_DUP:         legal = (depth != '0) && (depth != CAP);
            default:        legal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid && legal) begin
                    if (cmd_op == OP_PUSH)
                        state_nxt = PUSH1;
                    else if (cmd_op inside {OP_POP, OP_ADD, OP_SUB, OP_DUP})
                        state_nxt = POP_A;
                end
            end
            POP_A:  state_nxt = is_arith ? POP_B : CAP_B;
            POP_B:  state_nxt = CAP_B;
            CAP_B:  state_nxt = (op == OP_POP) ? RESULT : PUSH1;
            PUSH1:  state_nxt = (op == OP_DUP) ? PUSH2 : IDLE;
            PUSH2:  state_nxt = IDLE;
            RESULT: state_nxt = res_ready ? IDLE : RESULT;
            HALT:   state_nxt = HALT;
        endcase
        // A stack fault freezes the block until reset
        if (stk_ovf || stk_unf)
            state_nxt = HALT;
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        stk_pop   = (state == POP_A) || (state == POP_B);
        stk_push  = (state == PUSH1) || (state == PUSH2);
        stk_d     = '0;
        if (stk_push)
            stk_d = is_arith ? alu_y : opnd_b;
        res_valid = (state == RESULT);
        halt      = (state == HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op       <= OP_PUSH;
            opnd_a   <= '0;
            opnd_b   <= '0;
            res_data <= '0;
            depth    <= '0;
            err      <= 1'b0;
        end else begin
            if (cmd_ready && cmd_valid) begin
                op     <= cmd_op;
                opnd_b <= cmd_data;
                if (!legal)
                    err <= 1'b1;
            end
            if (state == POP_B)
                opnd_a <= stk_q;
            // stk_q lags stk_pop by one cycle, so CAP_B sees the last pop
            if (state == CAP_B) begin
                opnd_b <= stk_q;
                if (op == OP_POP)
                    res_data <= stk_q;
            end
            if (stk_push)
                depth <= depth + 1'b1;
            else if (stk_pop)
                depth <= depth - 1'b1;
        end
    end

endmodule

// File: doc/rpn_eval.md
RPN_EVAL -- requirements
Module: rpn_eval

Interface
REQ-001 Parameter WIDTH, default 11: data word width; SHALL match the downstream stack's WIDTH.
REQ-002 Parameter DEPTH, default 7: stack address width; usable capacity CAP = 2**DEPTH - 1 entries.
REQ-003 Port list (name  direction  width  meaning) SHALL be:
 clk  in  1  clock, all logic on rising edge.
 reset  in  1  synchronous, active-high.
 cmd_valid  in  1  command offered.
 cmd_ready  out  1  command accepted when valid&&ready.
 cmd_op  in  3  0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 DUP, 5-7 NOP.
 cmd_data  in  WIDTH  PUSH operand.
 res_valid  out  1  POP result available.
 res_ready  in  1  result consumed when valid&&ready.
 res_data  out  WIDTH  POP result.
 stk_push  out  1  one-cycle push strobe to stack.
 stk_pop  out  1  one-cycle pop strobe to stack.
 stk_d  out  WIDTH  push data.
 stk_q  in  WIDTH  popped word, valid the cycle after stk_pop.
 stk_ovf  in  1  stack sticky overflow.
 stk_unf  in  1  stack sticky underflow.
 depth  out  DEPTH+1  current entry count.
 err  out  1  sticky illegal-command flag.
 halt  out  1  stack fault seen; block frozen.

Function
REQ-004 States SHALL be IDLE, POP_A, POP_B, CAP_B, PUSH1, PUSH2, RESULT, HALT.
REQ-005 cmd_ready SHALL be 1 only in IDLE.
REQ-006 stk_push and stk_pop SHALL never be asserted in the same cycle, and each SHALL be asserted for exactly one cycle per stack access.
REQ-007 PUSH: if depth<CAP, assert stk_push with stk_d=cmd_data in the cycle after acceptance (state PUSH1), depth+1, then return to IDLE.
REQ-008 POP: if depth>=1, POP_A issues stk_pop; the next cycle captures stk_q into res_data and enters RESULT with res_valid=1; res_valid and res_data SHALL hold until res_ready, then return to IDLE; depth-1.
REQ-009 ADD/SUB: if depth>=2, POP_A pops a; POP_B captures a and pops b; CAP_B captures b; PUSH1 pushes b+a (ADD) or b-a (SUB); net depth-1; latency from acceptance to push SHALL be 4 cycles.
REQ-010 DUP: if depth>=1 and depth<CAP, pop a, push a (PUSH1), push a (PUSH2); net depth+1.
REQ-011 Illegal command (POP/DUP at depth 0, ADD/SUB at depth<2, PUSH/DUP at depth CAP): SHALL be consumed, SHALL cause no stack strobe, SHALL set err, depth unchanged.
REQ-012 NOP SHALL be consumed with no effect.
REQ-013 Arithmetic SHALL be unsigned modulo 2**WIDTH unless REQ-018 applies.
REQ-014 If stk_ovf or stk_unf is sampled high in any state, the FSM SHALL enter HALT at the next edge: cmd_ready=0, no strobes, res_valid=0, halt=1, until reset.
REQ-015 depth SHALL update in the same cycle as the corresponding stk_push/stk_pop strobe.

Reset
REQ-016 On reset the block SHALL enter IDLE with depth=0, err=0, halt=0, res_valid=0, res_data=0, stk_push=0, stk_pop=0, stk_d=0, regardless of the state in flight.
REQ-017 A command mid-sequence at reset SHALL be abandoned with no further strobes; the stack SHALL be reset in the same cycle by the system.

Configuration
REQ-018 Macro RPN_EVAL_SAT_EN: when defined, ADD SHALL clamp to all-ones on carry and SUB SHALL clamp to 0 on borrow; when undefined, wrap per REQ-013.

Structure
REQ-019 Package rpn_eval_pkg SHALL hold the op-code constants and the state enumeration.
REQ-020 Combinational sub-module rpn_eval_alu SHALL compute add/sub including the RPN_EVAL_SAT_EN option.

Verification
REQ-021 PUSH 5, PUSH 3, ADD, POP -> res_data=8, depth 0, err=0.
REQ-022 PUSH 3, PUSH 5, SUB, POP -> res_data=2046 (wrap); with RPN_EVAL_SAT_EN -> 0.
REQ-023 POP at depth 0 -> no stk_pop, err=1, depth 0; subsequent PUSH 7, POP -> 7.
REQ-024 PUSH 9, DUP, ADD, POP with res_ready held low 5 cycles -> res_data=18 stable and res_valid high throughout, then released.
REQ-025 127 PUSHes then PUSH -> 128th rejected, err=1, depth=127; force stk_unf=1 -> halt=1, cmd_ready=0.
REQ-026 Reset asserted during CAP_B of ADD -> next cycle IDLE, depth=0, no strobes.
